// File: rtl/minimac_pkg.sv
// Shared definitions for the minimac receive/transmit datapaths.
// Holds FSM encoding, CRC constants and the byte-wise CRC step.
package minimac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DISCARD,
        DONE
    } state_t;

    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam int          RUNT_LEN    = 64;

    localparam int ST_PHY  = 0;
    localparam int ST_CRC  = 1;
    localparam int ST_RUNT = 2;

    // Serial Ethernet CRC, wire order: byte LSB first into an MSB-shift register.
    function automatic logic [31:0] crc32_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i])
                r = {r[30:0], 1'b0} ^ CRC_POLY;
            else
                r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

endpackage

// File: rtl/minimac_rxdma_if.sv
// Receive FIFO pop side plus slot RAM write port of the RX DMA.
interface minimac_rxdma_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  rx_empty;
    logic                  rx_ack;
    logic                  rx_eof;
    logic [7:0]            rx_data;
    logic [ADDR_WIDTH-3:0] mem_adr;
    logic [31:0]           mem_dat;
    logic [3:0]            mem_sel;
    logic                  mem_we;

    modport master (
        input  rx_empty, rx_eof, rx_data,
        output rx_ack, mem_adr, mem_dat, mem_sel, mem_we
    );

    modport slave (
        output rx_empty, rx_eof, rx_data,
        input  rx_ack, mem_adr, mem_dat, mem_sel, mem_we
    );
endinterface

// File: rtl/minimac_crc32.sv
// Byte-wise Ethernet CRC32 register, shared by the RX and TX paths.
module minimac_crc32
    import minimac_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [31:0] i_init,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_crc <= CRC_INIT;
        else if (i_clr)
            r_crc <= i_init;
        else if (i_en)
            r_crc <= crc32_byte(r_crc, i_data);
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/minimac_rxdma.sv
// RX frame sink: packs FIFO bytes into slot RAM words, checks FCS and length,
// reports per-frame status and counts dropped frames.
module minimac_rxdma
    import minimac_pkg::*;
#(
    parameter int MAX_LEN    = 1530,
    parameter int ADDR_WIDTH = 11
)(
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    minimac_rxdma_if.master       bus,
    input  logic                  slot_ready,
    output logic                  slot_done,
    output logic [ADDR_WIDTH-1:0] slot_count,
    output logic [2:0]            slot_status,
    output logic [15:0]           drop_count
);

    localparam logic [ADDR_WIDTH-1:0] L_MAX  = ADDR_WIDTH'(MAX_LEN);
    localparam logic [ADDR_WIDTH-1:0] L_RUNT = ADDR_WIDTH'(RUNT_LEN);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [31:0]           r_word;
    logic [3:0]            r_sel;
    logic [31:0]           w_crc;
    logic [2:0]            w_status;
    logic                  w_pop;
    logic                  w_take;
    logic                  w_end;
    logic                  w_drop;
    logic                  w_clr;

    assign w_pop = sys_rst_n & ~bus.rx_empty & (r_state != DONE);
    assign bus.rx_ack = w_pop;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_end  = 1'b0;
        w_drop = 1'b0;
        w_clr  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pop && !bus.rx_eof) begin
                    if (slot_ready) begin
                        w_take = 1'b1;
                        w_next = RECV;
                    end else begin
                        w_drop = 1'b1;
                        w_next = DISCARD;
                    end
                end
            end
            RECV: begin
                if (w_pop) begin
                    if (bus.rx_eof) begin
                        w_end  = 1'b1;
                        w_next = DONE;
                    end else if (r_count == L_MAX) begin
                        // Oversize: slot stays armed, next frame restarts at word 0
                        w_drop = 1'b1;
                        w_clr  = 1'b1;
                        w_next = DISCARD;
                    end else begin
                        w_take = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (w_pop && bus.rx_eof)
                    w_next = IDLE;
            end
            DONE: begin
                w_clr  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_status          = 3'b000;
        w_status[ST_PHY]  = bus.rx_data[0];
        w_status[ST_CRC]  = (w_crc != CRC_RESIDUE) & ~bus.rx_data[0];
        w_status[ST_RUNT] = r_count < L_RUNT;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_count     <= '0;
            r_word      <= '0;
            r_sel       <= '0;
            bus.mem_we  <= 1'b0;
            bus.mem_adr <= '0;
            bus.mem_dat <= '0;
            bus.mem_sel <= '0;
            slot_done   <= 1'b0;
            slot_count  <= '0;
            slot_status <= '0;
            drop_count  <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            slot_done  <= 1'b0;
            if (w_take) begin
                r_word[{r_count[1:0], 3'b000} +: 8] <= bus.rx_data;
                r_count <= r_count + ADDR_WIDTH'(1);
                if (r_count[1:0] == 2'd3) begin
                    bus.mem_we  <= 1'b1;
                    bus.mem_adr <= r_count[ADDR_WIDTH-1:2];
                    bus.mem_dat <= {bus.rx_data, r_word[23:0]};
                    bus.mem_sel <= 4'hF;
                    r_sel       <= 4'h0;
                end else begin
                    r_sel[r_count[1:0]] <= 1'b1;
                end
            end
            if (w_end) begin
                if (|r_sel) begin
                    bus.mem_we  <= 1'b1;
                    bus.mem_adr <= r_count[ADDR_WIDTH-1:2];
                    bus.mem_dat <= r_word;
                    bus.mem_sel <= r_sel;
                end
                slot_done   <= 1'b1;
                slot_count  <= r_count;
                slot_status <= w_status;
            end
            if (w_clr) begin
                r_count <= '0;
                r_sel   <= '0;
            end
            if (w_drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    minimac_crc32 u_crc (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .i_clr  (w_clr),
        .i_en   (w_take),
        .i_init (CRC_INIT),
        .i_data (bus.rx_data),
        .o_crc  (w_crc)
    );

endmodule

// File: tb/tb_minimac_rxdma.sv
// Scoreboard bench for minimac_rxdma: FIFO/CSR models drive frames, a monitor
// checks RAM writes and slot reports against a frame-level reference model.
module tb_minimac_rxdma;
    import minimac_pkg::*;

    localparam int MAXL = 1530;
    localparam int AW   = 11;

    typedef struct {
        logic       eof;
        logic [7:0] d;
        bit         mark;
    } ent_t;

    typedef struct {
        logic [AW-3:0] adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
    } wr_t;

    typedef struct {
        logic [AW-1:0] cnt;
        logic [2:0]    st;
    } done_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          slot_ready = 1'b0;
    logic          slot_done;
    logic [AW-1:0] slot_count;
    logic [2:0]    slot_status;
    logic [15:0]   drop_count;

    ent_t       fifo_q[$];
    wr_t        exp_wr[$];
    done_t      exp_done[$];
    logic [7:0] fr[$];

    int n_chk = 0;
    int n_fail = 0;
    int model_drop = 0;
    bit model_ready = 0;
    bit gaps = 0;
    bit ignore = 0;
    bit done_due = 0;

    minimac_rxdma_if #(.ADDR_WIDTH(AW)) bus();

    minimac_rxdma #(.MAX_LEN(MAXL), .ADDR_WIDTH(AW)) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .bus         (bus),
        .slot_ready  (slot_ready),
        .slot_done   (slot_done),
        .slot_count  (slot_count),
        .slot_status (slot_status),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Reference CRC32 (reflected table-free form), returns the FCS value
    function automatic logic [31:0] crc_of(int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, fr[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(int len, bit bad);
        logic [31:0] c;
        logic [7:0]  m;
        int          idx;
        fr.delete();
        for (int i = 0; i < len - 4; i++)
            fr.push_back(8'($urandom));
        c = crc_of(len - 4);
        for (int k = 0; k < 4; k++)
            fr.push_back(c[8*k +: 8]);
        if (bad) begin
            idx = len - 4 + $urandom_range(0, 3);
            m = 8'h01 << $urandom_range(0, 7);
            fr[idx] = fr[idx] ^ m;
        end
    endtask

    task automatic push_words(int nbytes, bit partial);
        int nw;
        nw = partial ? (nbytes + 3) / 4 : nbytes / 4;
        for (int w = 0; w < nw; w++) begin
            wr_t e;
            e.adr = (AW-2)'(w);
            e.dat = '0;
            e.sel = '0;
            for (int b = 0; b < 4; b++) begin
                if (4*w + b < nbytes) begin
                    e.dat[8*b +: 8] = fr[4*w + b];
                    e.sel[b] = 1'b1;
                end
            end
            exp_wr.push_back(e);
        end
    endtask

    // Frame-level model: decides store/drop from the slot arming state
    task automatic send(logic [7:0] eofb);
        int    len;
        bit    store;
        bit    ok;
        done_t d;
        len = fr.size();
        store = 0;
        if (model_ready && len <= MAXL) begin
            push_words(len, 1);
            ok = crc_of(len - 4) == {fr[len-1], fr[len-2], fr[len-3], fr[len-4]};
            d.cnt = AW'(len);
            d.st  = {len < 64, !eofb[0] && !ok, eofb[0]};
            exp_done.push_back(d);
            store = 1;
            model_ready = 0;
        end else begin
            if (model_ready)
                push_words(MAXL, 0);
            if (model_drop < 65535)
                model_drop++;
        end
        for (int i = 0; i < len; i++)
            fifo_q.push_back('{1'b0, fr[i], 1'b0});
        fifo_q.push_back('{1'b1, eofb, store});
    endtask

    task automatic arm(bit r);
        @(negedge clk);
        slot_ready  = r;
        model_ready = r;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((fifo_q.size() != 0 || exp_done.size() != 0 ||
                exp_wr.size() != 0) && t < 6000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (t >= 6000) begin
            n_fail++;
            $display("FAIL drain: timeout with %0d fifo entries, required 0",
                     fifo_q.size());
        end
        chk("drop_count", 32'(drop_count), 32'(model_drop));
    endtask

    // FWFT receive FIFO model
    initial begin
        bit took;
        bus.rx_empty = 1'b1;
        bus.rx_eof   = 1'b0;
        bus.rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (fifo_q.size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
                bus.rx_empty = 1'b0;
                bus.rx_eof   = fifo_q[0].eof;
                bus.rx_data  = fifo_q[0].d;
            end else begin
                bus.rx_empty = 1'b1;
                bus.rx_eof   = 1'b0;
                bus.rx_data  = 8'h00;
            end
            #2;
            took = bus.rx_ack;
            @(posedge clk);
            done_due = 0;
            if (took && fifo_q.size() > 0) begin
                done_due = fifo_q[0].mark;
                void'(fifo_q.pop_front());
            end
        end
    end

    // Monitor: RAM writes, slot reports, and CSR clearing slot_ready
    initial begin
        wr_t         e;
        done_t       d;
        logic [31:0] m;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (slot_done || done_due)
                    chk("done_timing", 32'(slot_done), 32'(done_due));
                if (bus.mem_we && !ignore) begin
                    if (exp_wr.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL mem_write: write at adr %h, required none",
                                 bus.mem_adr);
                    end else begin
                        e = exp_wr.pop_front();
                        for (int b = 0; b < 4; b++)
                            m[8*b +: 8] = {8{e.sel[b]}};
                        chk("mem_adr", 32'(bus.mem_adr), 32'(e.adr));
                        chk("mem_sel", 32'(bus.mem_sel), 32'(e.sel));
                        chk("mem_dat", bus.mem_dat & m, e.dat);
                    end
                end
                if (slot_done) begin
                    slot_ready = 1'b0;
                    if (!ignore) begin
                        if (exp_done.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL slot_done: pulse with count %0d, required none",
                                     slot_count);
                        end else begin
                            d = exp_done.pop_front();
                            chk("slot_count", 32'(slot_count), 32'(d.cnt));
                            chk("slot_status", 32'(slot_status), 32'(d.st));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_zero(string tag);
        chk({tag, "_rx_ack"}, 32'(bus.rx_ack), 0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_mem_adr"}, 32'(bus.mem_adr), 0);
        chk({tag, "_mem_dat"}, bus.mem_dat, 0);
        chk({tag, "_mem_sel"}, 32'(bus.mem_sel), 0);
        chk({tag, "_slot_done"}, 32'(slot_done), 0);
        chk({tag, "_slot_count"}, 32'(slot_count), 0);
        chk({tag, "_slot_status"}, 32'(slot_status), 0);
        chk({tag, "_drop_count"}, 32'(drop_count), 0);
    endtask

    initial begin
        int len;
        logic [7:0] eb;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Minimum-size and odd-size good frames
        arm(1); build(64, 0); send(8'h00); drain();
        arm(1); build(67, 0); send(8'h00); drain();
        // PHY error masks the CRC error bit
        arm(1); build(100, 1); send(8'h01); drain();
        // Slot not armed: whole frame dropped
        arm(0); build(80, 0); send(8'h00); drain();
        // Oversize frame, then a good frame from address 0
        arm(1); build(MAXL + 1, 0); send(8'h00); drain();
        build(70, 0); send(8'h00); drain();
        // Bad FCS, then runt
        arm(1); build(64, 1); send(8'h00); drain();
        arm(1); build(40, 0); send(8'h00); drain();

        // Back-to-back frames with FIFO gaps: only the first finds the slot armed
        gaps = 1;
        arm(1);
        build(90, 0); send(8'h00);
        build(33, 0); send(8'h00);
        build(150, 1); send(8'h00);
        drain();

        // Stray end marker in IDLE is dropped silently
        arm(1);
        fifo_q.push_back('{1'b1, 8'h00, 1'b0});
        build(72, 0); send(8'h00); drain();

        for (int i = 0; i < 8; i++) begin
            arm($urandom_range(0, 3) != 0);
            len = $urandom_range(20, 200);
            build(len, $urandom_range(0, 3) == 0);
            eb = 8'($urandom);
            eb[0] = ($urandom_range(0, 4) == 0);
            send(eb);
            drain();
        end
        gaps = 0;

        // Reset in the middle of a frame
        arm(1);
        ignore = 1;
        build(100, 0);
        for (int i = 0; i < 100; i++)
            fifo_q.push_back('{1'b0, fr[i], 1'b0});
        fifo_q.push_back('{1'b1, 8'h00, 1'b0});
        repeat (30) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        fifo_q.delete();
        model_drop = 0;
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        ignore = 0;
        build(64, 0); send(8'h00); drain();

        chk("exp_wr_left", 32'(exp_wr.size()), 0);
        chk("exp_done_left", 32'(exp_done.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
